jtframe_db15_scan: RTL and testbench

- Parametrised serial joystick scanner for DB15/SNAC adapters on the MiSTer user port; supersedes the fixed two-player serial readout in the frame.
- Drives a 74HC165-style shift-register chain: one latch pulse, then shifts out PLAYERS*BITS bits.
- Deserialises the bits, inverts them to active-high and publishes all player words atomically at scan end.
- Sits between the user port pins and the jtframe input mux. Polls continuously at a programmable interval.

---
 rtl/jtframe_db15_scan.sv | 181 ++++++++++++++++++
 tb/tb_jtframe_db15_scan.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_db15_scan.sv
// Serial joystick scanner for 74HC165-style DB15/SNAC chains.
// Latches the chain, shifts active*BITS bits and publishes them atomically.
module jtframe_db15_scan #(
  parameter int PLAYERS = 2,
  parameter int BITS    = 12,
  parameter int DIV     = 8,
  parameter int POLL    = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              mode,
  input  logic                    joy_data,
  output logic                    joy_clk,
  output logic                    joy_load,
  output logic [PLAYERS*BITS-1:0] joy_out,
  output logic                    valid,
  output logic                    scanning
);

  localparam int NB = PLAYERS * BITS;
  localparam int KW = (NB > 1) ? $clog2(NB) : 1;
  localparam int DW = $clog2(2 * DIV);
  localparam int PW = $clog2(POLL + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [1:0]      sync;
  logic [1:0]      mode_q;
  logic            kick;
  logic            phase;
  logic [DW-1:0]   tcnt;
  logic [KW-1:0]   k;
  logic [PW-1:0]   pcnt;
  logic [NB-1:0]   raw;
  logic [NB-1:0]   upd;
  logic [2:0]      active;
  logic [KW:0]     nbits;
  logic [KW-1:0]   last_k;
  logic            mode_chg;
  logic            mode_off;
  logic            end_load;
  logic            end_half;
  logic            poll_hit;

  always_comb begin
    active = {1'b0, mode};
    if (active > 3'(PLAYERS))
      active = 3'(PLAYERS);
  end

  assign nbits    = (KW+1)'(active) * (KW+1)'(BITS);
  assign last_k   = KW'(nbits - 1'b1);
  assign mode_chg = mode != mode_q;
  assign mode_off = mode == 2'd0;
  assign end_load = tcnt == DW'(2 * DIV - 1);
  assign end_half = tcnt == DW'(DIV - 1);
  assign poll_hit = pcnt == PW'(POLL);

  // inverted, masked snapshot of the chain for the publish edge
  always_comb begin
    upd = '0;
    for (int i = 0; i < NB; i++)
      if ((KW+1)'(i) < nbits)
        upd[i] = ~raw[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (!mode_off && (kick || mode_chg || poll_hit))
          state_nx = LOAD;
      LOAD:
        if (mode_chg)
          state_nx = IDLE;
        else if (end_load)
          state_nx = SHIFT;
      SHIFT:
        if (mode_chg)
          state_nx = IDLE;
        else if (phase && end_half && k == last_k)
          state_nx = DONE;
      DONE:
        state_nx = IDLE;
    endcase
  end

  always_comb begin
    joy_load = state != LOAD;
    joy_clk  = !(state == SHIFT && !phase);
    scanning = state == LOAD || state == SHIFT;
    valid    = state == DONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= 2'b11;
      mode_q <= 2'd0;
    end else begin
      sync   <= {sync[0], joy_data};
      mode_q <= mode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      kick <= 1'b1;
    else if (state_nx == LOAD)
      kick <= 1'b0;
    else if (mode_chg)
      kick <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tcnt <= '0;
    else if (state_nx != state || (state == SHIFT && end_half))
      tcnt <= '0;
    else if (scanning)
      tcnt <= tcnt + 1'b1;
  end

  // phase 0 is the joy_clk low half of a bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      phase <= 1'b0;
    else if (state_nx != SHIFT)
      phase <= 1'b0;
    else if (state == SHIFT && end_half)
      phase <= ~phase;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      k <= '0;
    else if (state_nx != SHIFT)
      k <= '0;
    else if (state == SHIFT && phase && end_half)
      k <= k + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      raw <= '0;
    else if (state == SHIFT && !phase && end_half)
      raw[k] <= sync[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pcnt <= '0;
    else if (state != IDLE || state_nx != IDLE || mode_off)
      pcnt <= '0;
    else if (!poll_hit)
      pcnt <= pcnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      joy_out <= '0;
    else if (mode_off)
      joy_out <= '0;
    else if (state == SHIFT && state_nx == DONE)
      joy_out <= upd;
  end

endmodule

// File: tb/tb_jtframe_db15_scan.sv
// Bench for jtframe_db15_scan: 165-chain model, timeline scoreboard
// and directed scenarios with literal expectations.
module tb_jtframe_db15_scan;

  localparam int PLAYERS = 2;
  localparam int BITS    = 12;
  localparam int DIV     = 4;
  localparam int POLL    = 100;
  localparam int NB      = PLAYERS * BITS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic          joy_data;
  logic          joy_clk;
  logic          joy_load;
  logic [NB-1:0] joy_out;
  logic          valid;
  logic          scanning;

  jtframe_db15_scan #(
    .PLAYERS(PLAYERS),
    .BITS(BITS),
    .DIV(DIV),
    .POLL(POLL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mode(mode),
    .joy_data(joy_data),
    .joy_clk(joy_clk),
    .joy_load(joy_load),
    .joy_out(joy_out),
    .valid(valid),
    .scanning(scanning)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // shift-register chain: pressed is active-high, the wire is active-low
  logic [NB-1:0] pressed = 24'hA5A0F0;
  logic          tog_en = 1'b1;
  logic          tog = 1'b0;
  int            ptr = 0;

  always @(posedge joy_clk or negedge joy_load)
    if (!joy_load)
      ptr <= 0;
    else
      ptr <= ptr + 1;

  function automatic logic chain_bit(input int p);
    if (p < NB)
      return ~pressed[p];
    return 1'b1;
  endfunction

  assign joy_data = tog_en ? tog : chain_bit(ptr);

  function automatic int nbits_of(input int m);
    int a;
    a = (m > PLAYERS) ? PLAYERS : m;
    return a * BITS;
  endfunction

  function automatic logic [NB-1:0] mask_n(input int n);
    logic [NB-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++)
      if (i < n)
        r[i] = 1'b1;
    return r;
  endfunction

  // model: m_t is cycles since LOAD entry, -1 while idle
  int            m_t = -1;
  int            m_cnt = 0;
  int            m_prev = 0;
  bit            m_kick = 1'b1;
  logic [NB-1:0] m_out = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t = -1;
      m_cnt = 0;
      m_prev = 0;
      m_kick = 1'b1;
      m_out = '0;
    end else begin
      int m;
      int lp;
      bit chg;
      m = int'(mode);
      lp = 2 * DIV * (nbits_of(m_prev) + 1);
      chg = (m != m_prev);
      if (m == 0)
        m_out = '0;
      if (m_t >= 0) begin
        if (m_t == lp || chg) begin
          m_t = -1;
          m_cnt = 0;
        end else begin
          m_t++;
          if (m_t == lp)
            m_out = pressed & mask_n(nbits_of(m));
        end
      end else if (m != 0 && (m_kick || chg || m_cnt == POLL)) begin
        m_t = 0;
        m_cnt = 0;
      end else if (m == 0) begin
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
      if (m_t == 0)
        m_kick = 1'b0;
      else if (chg)
        m_kick = 1'b1;
      m_prev = m;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      int l;
      logic ec;
      logic el;
      logic ev;
      logic es;
      l  = 2 * DIV * (nbits_of(m_prev) + 1);
      el = !(m_t >= 0 && m_t < 2 * DIV);
      ev = (m_t == l);
      es = (m_t >= 0 && m_t < l);
      ec = 1'b1;
      if (m_t >= 2 * DIV && m_t < l)
        ec = ((m_t - 2 * DIV) % (2 * DIV)) >= DIV;
      chk("cycle", {joy_clk, joy_load, valid, scanning, joy_out},
          {ec, el, ev, es, m_out});
    end
  end

  // event monitor
  int   cyc = 0;
  logic pl = 1'b1;
  logic pc = 1'b1;
  int   t_load = 0;
  int   prev_load = 0;
  int   loads = 0;
  int   load_lo = 0;
  int   pulses = 0;
  int   vcount = 0;
  int   v_idx = 0;

  always @(posedge clk)
    cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pl && !joy_load) begin
      prev_load = t_load;
      t_load = cyc;
      loads++;
      pulses = 0;
      load_lo = 0;
    end
    if (!joy_load)
      load_lo++;
    if (!pc && joy_clk)
      pulses++;
    if (valid) begin
      vcount++;
      v_idx = cyc - t_load + 1;
    end
    pl = joy_load;
    pc = joy_clk;
  end

  task automatic wait_valid(input string name, input int maxc);
    int v0;
    int c;
    v0 = vcount;
    c = 0;
    while (vcount == v0 && c < maxc) begin
      @(posedge clk);
      c++;
    end
    chk(name, 64'(vcount > v0), 64'd1);
    #2;
  endtask

  task automatic wait_shift(input string name, input int l0, input int p);
    int c;
    c = 0;
    do begin
      @(posedge clk);
      #2;
      c++;
    end while (!(loads > l0 && pulses >= p && !joy_clk) && c < 600);
    chk(name, 64'(c < 600), 64'd1);
  endtask

  initial begin
    int v0;
    int ta;
    int l0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_out", joy_out, 0);
    chk("rst_pins", {joy_clk, joy_load, valid, scanning}, 4'b1100);
    rst_n = 1'b1;

    repeat (5000) begin
      @(posedge clk);
      #2 tog = ~tog;
    end
    chk("off_valid", vcount, 0);
    chk("off_loads", loads, 0);
    chk("off_pins", {joy_clk, joy_load}, 2'b11);
    chk("off_out", joy_out, 0);

    tog_en = 1'b0;
    @(posedge clk);
    #2 mode = 2'd2;
    wait_valid("scan2_timeout", 400);
    chk("scan2_load_len", load_lo, 8);
    chk("scan2_pulses", pulses, 24);
    chk("scan2_valid_at", v_idx, 201);
    chk("scan2_out", joy_out, 24'hA5A0F0);

    mode = 2'd1;
    wait_valid("scan1_timeout", 400);
    chk("scan1_pulses", pulses, 12);
    chk("scan1_valid_at", v_idx, 105);
    chk("scan1_out", joy_out, 24'h0000F0);

    mode = 2'd3;
    wait_valid("clamp_timeout", 400);
    chk("clamp_pulses", pulses, 24);
    chk("clamp_valid_at", v_idx, 201);
    chk("clamp_out", joy_out, 24'hA5A0F0);

    wait_valid("poll_timeout", 700);
    chk("poll_gap", t_load - prev_load, 302);
    chk("poll_pulses", pulses, 24);

    l0 = loads;
    mode = 2'd2;
    wait_shift("abort_reach", l0, 10);
    chk("abort_bit", pulses, 10);
    v0 = vcount;
    mode = 2'd1;
    @(posedge clk);
    #2;
    chk("abort_pins", {joy_clk, joy_load, scanning}, 3'b110);
    chk("abort_out", joy_out, 24'hA5A0F0);
    ta = cyc;
    wait_valid("abort_rescan", 400);
    chk("abort_gap", t_load - ta, 1);
    chk("abort_vcount", vcount - v0, 1);
    chk("abort_pulses", pulses, 12);
    chk("abort_valid_at", v_idx, 105);
    chk("abort_out2", joy_out, 24'h0000F0);

    l0 = loads;
    mode = 2'd2;
    wait_shift("rst_reach", l0, 3);
    chk("rst_scanning", scanning, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_pins", {joy_clk, joy_load, valid, scanning}, 4'b1100);
    chk("rst_async_out", joy_out, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    wait_valid("post_rst_timeout", 400);
    chk("post_rst_valid_at", v_idx, 201);
    chk("post_rst_out", joy_out, 24'hA5A0F0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
